lagarto_l15_arbiter: RTL



---
 rtl/lagarto_l15_arb_pkg.sv | 31 +++
 rtl/lagarto_rr_arbiter.sv | 60 ++++++
 rtl/lagarto_l15_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lagarto_l15_arb_pkg.sv
// Shared definitions for the Lagarto L1.5 request-port arbiter:
// requester indices, default widths and the threadid table entry.
package lagarto_l15_arb_pkg;

  // Fixed requester slots on the tile-side port.
  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;
  localparam int REQ_UNC    = 2;

  // Default geometry of the arbiter.
  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_TID_W     = 2;
  localparam int DEF_PAYLOAD_W = 112;
  localparam int DEF_RTRN_W    = 160;

  // Owner field is sized for the largest supported requester count (8).
  localparam int OWNER_W = 3;

  // One entry per L1.5 threadid: in-flight flag and the requester it belongs to.
  typedef struct packed {
    logic               busy;
    logic [OWNER_W-1:0] owner;
  } tid_entry_t;

  // Issue register state: empty, or holding a request for the L1.5.
  typedef enum logic [0:0] {
    ISS_IDLE = 1'b0,
    ISS_HOLD = 1'b1
  } iss_state_e;

endpackage

// File: rtl/lagarto_rr_arbiter.sv
// N-wide round-robin picker. The winner is the first active request at or
// after the pointer (wrapping); the pointer advances past the winner when
// en_i is set.
module lagarto_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [N-1:0]     upper_s;
  logic [N-1:0]     lower_s;
  logic [N-1:0]     sel_s;
  logic             found_s;

  // Split requests around the pointer; prefer the upper segment, then pick its lowest index.
  always_comb begin
    upper_s = '0;
    lower_s = '0;
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      upper_s[i] = req_i[i] & (IDX_W'(i) >= ptr_q);
      lower_s[i] = req_i[i] & (IDX_W'(i) <  ptr_q);
    end
    sel_s = (|upper_s) ? upper_s : lower_s;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = sel_s[i] & ~found_s;
      idx_o    = (sel_s[i] & ~found_s) ? IDX_W'(i) : idx_o;
      found_s  = found_s | sel_s[i];
    end
    any_o = |req_i;
  end

  // Next pointer: one past the winner, wrapping at N.
  always_comb begin
    ptr_d = (en_i & any_o) ?
            ((idx_o == IDX_W'(N - 1)) ? '0 : idx_o + IDX_W'(1'b1)) :
            ptr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lagarto_l15_arbiter.sv
// Shares the single L1.5 request/return port among NUM_REQ core clients.
// Requests are picked round-robin, tagged with the lowest free threadid and
// held until the L1.5 header ack; returns are steered back to the owner of
// their threadid. Also reports idle status and a sticky protocol error.
module lagarto_l15_arbiter
  import lagarto_l15_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int TID_W     = DEF_TID_W,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int RTRN_W    = DEF_RTRN_W,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         l15_val_o,
  output logic [PAYLOAD_W-1:0]         l15_payload_o,
  output logic [TID_W-1:0]             l15_tid_o,
  input  logic                         l15_header_ack_i,
  input  logic                         l15_rtrn_val_i,
  input  logic [TID_W-1:0]             l15_rtrn_tid_i,
  input  logic                         l15_rtrn_last_i,
  input  logic [RTRN_W-1:0]            l15_rtrn_payload_i,
  output logic                         l15_rtrn_ack_o,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [RTRN_W-1:0]            rsp_payload_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  input  logic                         drain_i,
  output logic                         idle_o,
  output logic                         err_o
);

  localparam int NUM_TID = 2 ** TID_W;

  iss_state_e           state_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [TID_W-1:0]     tid_q;
  logic                 err_q;
  tid_entry_t           tbl_q [NUM_TID];
  tid_entry_t           tbl_d [NUM_TID];

  logic [NUM_TID-1:0]   busy_s;
  logic [TID_W-1:0]     free_tid_s;
  logic                 any_free_s;
  logic                 found_s;
  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic [IDX_W-1:0]     arb_idx_s;
  logic                 arb_any_s;
  logic                 grant_s;
  logic [PAYLOAD_W-1:0] win_payload_s;
  logic                 rtrn_busy_s;
  logic [NUM_REQ-1:0]   route_s;
  logic                 rtrn_ready_s;
  logic                 free_en_s;

  lagarto_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_valid_i),
    .en_i   (grant_s),
    .gnt_o  (arb_gnt_s),
    .idx_o  (arb_idx_s),
    .any_o  (arb_any_s)
  );

  // Registered busy vector and the lowest-numbered free threadid.
  always_comb begin
    busy_s     = '0;
    free_tid_s = '0;
    found_s    = 1'b0;
    for (int t = 0; t < NUM_TID; t++) begin
      busy_s[t] = tbl_q[t].busy;
    end
    for (int t = 0; t < NUM_TID; t++) begin
      free_tid_s = (~busy_s[t] & ~found_s) ? TID_W'(t) : free_tid_s;
      found_s    = found_s | ~busy_s[t];
    end
    any_free_s = ~&busy_s;
  end

  // Grant when the issue register frees up this cycle, drain is off and a tid is free.
  always_comb begin
    grant_s       = ((state_q == ISS_IDLE) | l15_header_ack_i) & ~drain_i &
                    any_free_s & arb_any_s;
    req_ready_o   = grant_s ? arb_gnt_s : '0;
    win_payload_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_payload_s = arb_gnt_s[i] ? req_payload_i[i*PAYLOAD_W +: PAYLOAD_W] : win_payload_s;
    end
  end

  // Return steering: route by the owner of the returning tid; drop returns on free tids.
  always_comb begin
    rtrn_busy_s = busy_s[l15_rtrn_tid_i];
    for (int i = 0; i < NUM_REQ; i++) begin
      route_s[i] = (tbl_q[l15_rtrn_tid_i].owner == OWNER_W'(i));
    end
    rtrn_ready_s   = |(rsp_ready_i & route_s);
    rsp_valid_o    = route_s & {NUM_REQ{l15_rtrn_val_i & rtrn_busy_s}};
    rsp_payload_o  = l15_rtrn_payload_i;
    l15_rtrn_ack_o = l15_rtrn_val_i & (~rtrn_busy_s | rtrn_ready_s);
    free_en_s      = l15_rtrn_ack_o & rtrn_busy_s & l15_rtrn_last_i;
  end

  // Tid table next state: allocate on grant, release on the last return beat.
  always_comb begin
    for (int t = 0; t < NUM_TID; t++) begin
      tbl_d[t].busy  = (tbl_q[t].busy & ~(free_en_s & (l15_rtrn_tid_i == TID_W'(t)))) |
                       (grant_s & (free_tid_s == TID_W'(t)));
      tbl_d[t].owner = (grant_s & (free_tid_s == TID_W'(t))) ? OWNER_W'(arb_idx_s) :
                       tbl_q[t].owner;
    end
  end

  // Issue FSM with its held payload/tid, the tid table and the sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ISS_IDLE;
      payload_q <= '0;
      tid_q     <= '0;
      err_q     <= 1'b0;
      for (int t = 0; t < NUM_TID; t++) begin
        tbl_q[t] <= '0;
      end
    end else begin
      err_q <= err_q | (l15_rtrn_val_i & ~rtrn_busy_s);
      for (int t = 0; t < NUM_TID; t++) begin
        tbl_q[t] <= tbl_d[t];
      end
      case (state_q)
        ISS_IDLE: begin
          if (grant_s) begin
            state_q   <= ISS_HOLD;
            payload_q <= win_payload_s;
            tid_q     <= free_tid_s;
          end else begin
            state_q   <= ISS_IDLE;
          end
        end
        ISS_HOLD: begin
          if (grant_s) begin
            state_q   <= ISS_HOLD;
            payload_q <= win_payload_s;
            tid_q     <= free_tid_s;
          end else if (l15_header_ack_i) begin
            state_q   <= ISS_IDLE;
          end else begin
            state_q   <= ISS_HOLD;
          end
        end
        default: begin
          state_q <= ISS_IDLE;
        end
      endcase
    end
  end

  assign l15_val_o     = (state_q == ISS_HOLD);
  assign l15_payload_o = payload_q;
  assign l15_tid_o     = tid_q;
  assign err_o         = err_q;
  assign idle_o        = (state_q == ISS_IDLE) & ~|busy_s;

endmodule
